disp_chan_scheduler: RTL and testbench
======================================

Name: disp_chan_scheduler

Overview:
Controller that sequences the 8-channel 32-bit display multiplexer. It drives the mux channel select (Test) and enable (EN). It supports four modes: manual switch select, timed auto-rotation, push-button stepping, and freeze. On top of these modes, per-channel event requests pre-empt the normal sequence, are arbitrated round-robin, and are shown for a fixed hold time before the previous channel is restored.

Parameters:
DWELL, 8, clock cycles each channel is shown in auto mode (min 2)
HOLD, 6, clock cycles a granted event channel is shown (min 2)
CW, 32, width of dwell/hold counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
mode  in  2  00 manual, 01 auto, 10 step, 11 freeze
sw_sel  in  3  manual channel select
step  in  1  step button level, already debounced; rising edge detected internally
ch_mask  in  8  channel enable, bit i = channel i displayable
evt_req  in  8  event request pulses, bit i = channel i
Test  out  3  mux channel select, registered
EN  out  1  mux enable, registered
evt_ack  out  8  one-cycle one-hot pulse when an event is granted
busy  out  1  high while an event is being shown

Behaviour:
- Reset (rst=0, async): Test=0, EN=0, evt_ack=0, busy=0, pend=0, rr_ptr=0, cnt=0, saved=0, step_q=0, state=NORM. All outputs are registered. No combinational path from any input to any output.
- pend[7:0]: pend |= evt_req every cycle. A grant clears its bit. If set and clear hit the same bit in the same cycle, set wins and the bit stays pending.
- eligible = pend & ch_mask. Masked pending bits stay pending and are not granted.
- nxt(c) = first enabled channel searching c+1, c+2, … wrapping 7→0, then c itself last. If ch_mask=0, nxt(c)=c.
- Freeze overrides. When mode=11, no grant is made in NORM.
- State NORM, mode 00: Test<=sw_sel; EN<=ch_mask[sw_sel]; latency 1 cycle.
- State NORM, mode 01: cnt increments each cycle. When cnt==DWELL-1: cnt<=0, Test<=nxt(Test).
- State NORM, mode 10: on step rising edge (step & ~step_q): Test<=nxt(Test).
- State NORM, mode 11: Test, cnt hold.
- State NORM, modes 01/10/11: EN<=ch_mask[Test_next].
- Mode change: any change of mode (registered compare) forces cnt<=0 in that cycle.
- NORM→EVT when eligible≠0 and mode≠11. In that edge:
  - g = first set bit of eligible searching rr_ptr, rr_ptr+1, … wrapping
  - saved<=Test; Test<=g; EN<=1; busy<=1; evt_ack<=onehot(g); pend[g]<=0; rr_ptr<=g+1 (mod 8); cnt<=0
  - the normal mode update is suppressed that cycle
- State EVT: evt_ack=0 after the first cycle. cnt increments each cycle. Mode, sw_sel and step are ignored; step edges in EVT are discarded. New requests only accumulate in pend, including for channel g.
- EVT exit: when cnt==HOLD-1, state<=NORM, cnt<=0, busy<=0. Test<=saved in modes 01/10/11; Test<=sw_sel in mode 00. EN per NORM rule.
- Back-to-back events: if eligible≠0 in the cycle after EVT exits, the next grant proceeds normally (one NORM cycle minimum between events).
- Event length: busy is high for exactly HOLD cycles per event. Test=g for exactly HOLD cycles.
- ch_mask=0 in auto/step: Test holds, EN=0, cnt still wraps.
- Reset mid-event: returns everything to reset values immediately; pending events are lost.

Test Plan:
- Reset, then mode=01, ch_mask=8'hFF → Test goes 0,1,2,…,7,0 advancing every 8 cycles; EN=1 throughout.
- mode=01, ch_mask=8'b1010_0100 starting at Test=2 → sequence 2,5,7,2; EN=1; ch_mask=0 → Test holds, EN=0.
- mode=00, sw_sel=5 with ch_mask[5]=0 → next cycle Test=5, EN=0; sw_sel=3 with ch_mask[3]=1 → Test=3, EN=1.
- mode=10, Test=1, step held high 20 cycles → Test=2 only once; release and press again → Test=3.
- mode=01, Test=4, evt_req=8'h41 in a single cycle, rr_ptr=0 → evt_ack=8'h01, Test=0 for 6 cycles; 1 NORM cycle with Test=4; then evt_ack=8'h40, Test=6 for 6 cycles; then Test=4; busy matches both windows.
- mode=11 with evt_req[2] pulsed → no ack, pend kept. Then mode=01 → grant on channel 2. Separately, assert rst=0 during EVT → Test=0, EN=0, busy=0 asynchronously.

Source files
------------

// File: rtl/disp_chan_scheduler_if.sv
// Signal bundle between the display channel scheduler and its controller/mux.
// Carries the mode controls, the event request/ack pair and the mux select/enable.
//
// Request/ack: evt_req[i] is a one-cycle pulse that latches a pending request for
// channel i; evt_ack is a one-hot, one-cycle pulse when that request is granted.
// There is no backpressure: a pending bit stays set until it is granted.
interface disp_chan_scheduler_if;
    logic [1:0] mode;
    logic [2:0] sw_sel;
    logic       step;
    logic [7:0] ch_mask;
    logic [7:0] evt_req;
    logic [2:0] Test;
    logic       EN;
    logic [7:0] evt_ack;
    logic       busy;
    logic       state_dbg;

    modport master (
        output mode, sw_sel, step, ch_mask, evt_req,
        input  Test, EN, evt_ack, busy, state_dbg
    );

    modport slave (
        input  mode, sw_sel, step, ch_mask, evt_req,
        output Test, EN, evt_ack, busy, state_dbg
    );
endinterface

// File: rtl/disp_chan_scheduler.sv
// Channel sequencer for the 8-channel display mux: manual/auto/step/freeze modes
// with round-robin event pre-emption that restores the previous channel afterwards.
module disp_chan_scheduler #(
    parameter int DWELL = 8,
    parameter int HOLD  = 6,
    parameter int CW    = 32
) (
    input logic                  clk,
    input logic                  rst,
    disp_chan_scheduler_if.slave bus
);
    localparam logic [0:0] ST_NORM = 1'b0;
    localparam logic [0:0] ST_EVT  = 1'b1;

    localparam logic [1:0] M_MAN  = 2'b00;
    localparam logic [1:0] M_AUTO = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;
    localparam logic [1:0] M_FRZ  = 2'b11;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);

    logic [0:0]    state, state_n;
    logic [2:0]    test_q, test_n;
    logic          en_q, en_n;
    logic [7:0]    ack_q, ack_n;
    logic          busy_q, busy_n;
    logic [7:0]    pend, pend_n;
    logic [2:0]    rr_ptr, rr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    saved, saved_n;
    logic          step_q;
    logic [1:0]    mode_q;
    logic [7:0]    eligible;
    logic [2:0]    grant;

    // Next displayable channel after c, wrapping; c itself is the last candidate.
    function automatic logic [2:0] nxt_chan(input logic [2:0] c, input logic [7:0] mask);
        logic [2:0] r;
        logic [2:0] idx;
        logic       found;
        r     = c;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = c + 3'(i);
            if (!found && mask[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // First eligible channel starting at the round-robin pointer.
    function automatic logic [2:0] rr_pick(input logic [7:0] elig, input logic [2:0] ptr);
        logic [2:0] r;
        logic [2:0] idx;
        logic       found;
        r     = ptr;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && elig[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign eligible = pend & bus.ch_mask;
    assign grant    = rr_pick(eligible, rr_ptr);

    always_comb begin
        state_n = state;
        test_n  = test_q;
        en_n    = en_q;
        ack_n   = 8'h00;
        busy_n  = busy_q;
        pend_n  = pend | bus.evt_req;
        rr_n    = rr_ptr;
        cnt_n   = cnt;
        saved_n = saved;

        case (state)
            ST_NORM: begin
                if (eligible != 8'h00 && bus.mode != M_FRZ) begin
                    // New requests in the grant cycle win over the clear.
                    pend_n  = (pend & ~(8'h01 << grant)) | bus.evt_req;
                    saved_n = test_q;
                    test_n  = grant;
                    en_n    = 1'b1;
                    busy_n  = 1'b1;
                    ack_n   = 8'h01 << grant;
                    rr_n    = grant + 3'd1;
                    cnt_n   = '0;
                    state_n = ST_EVT;
                end else begin
                    case (bus.mode)
                        M_MAN: begin
                            test_n = bus.sw_sel;
                            en_n   = bus.ch_mask[bus.sw_sel];
                        end
                        M_AUTO: begin
                            if (cnt == DWELL_LAST) begin
                                cnt_n  = '0;
                                test_n = nxt_chan(test_q, bus.ch_mask);
                            end else begin
                                cnt_n = cnt + CW'(1);
                            end
                            en_n = bus.ch_mask[test_n];
                        end
                        M_STEP: begin
                            if (bus.step && !step_q) begin
                                test_n = nxt_chan(test_q, bus.ch_mask);
                            end
                            en_n = bus.ch_mask[test_n];
                        end
                        default: begin
                            en_n = bus.ch_mask[test_q];
                        end
                    endcase
                    if (bus.mode != mode_q) begin
                        cnt_n = '0;
                    end
                end
            end
            default: begin
                if (cnt == HOLD_LAST) begin
                    state_n = ST_NORM;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    test_n  = (bus.mode == M_MAN) ? bus.sw_sel : saved;
                    en_n    = bus.ch_mask[test_n];
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        endcase
    end

    // step_q and mode_q track every cycle, so step edges seen during an event are consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_NORM;
            test_q <= 3'd0;
            en_q   <= 1'b0;
            ack_q  <= 8'h00;
            busy_q <= 1'b0;
            pend   <= 8'h00;
            rr_ptr <= 3'd0;
            cnt    <= '0;
            saved  <= 3'd0;
            step_q <= 1'b0;
            mode_q <= 2'b00;
        end else begin
            state  <= state_n;
            test_q <= test_n;
            en_q   <= en_n;
            ack_q  <= ack_n;
            busy_q <= busy_n;
            pend   <= pend_n;
            rr_ptr <= rr_n;
            cnt    <= cnt_n;
            saved  <= saved_n;
            step_q <= bus.step;
            mode_q <= bus.mode;
        end
    end

    assign bus.Test      = test_q;
    assign bus.EN        = en_q;
    assign bus.evt_ack   = ack_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_disp_chan_scheduler.sv
// Directed bench for disp_chan_scheduler: expected {Test,EN,busy,evt_ack} words are
// queued per cycle and compared against the DUT one clock later.
module tb_disp_chan_scheduler;
    localparam int W = 13;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] exp_q[$];

    disp_chan_scheduler_if bus ();

    disp_chan_scheduler #(.DWELL(8), .HOLD(6), .CW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input logic [2:0] t, input logic en, input logic b,
                        input logic [7:0] a, input int n);
        repeat (n) exp_q.push_back({t, en, b, a});
    endtask

    task automatic check_head(input string tag);
        logic [W-1:0] exp_v;
        logic [W-1:0] obs_v;
        exp_v = exp_q.pop_front();
        obs_v = {bus.Test, bus.EN, bus.busy, bus.evt_ack};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed Test=%0d EN=%b busy=%b ack=%h, expected Test=%0d EN=%b busy=%b ack=%h",
                   tag, obs_v[12:10], obs_v[9], obs_v[8], obs_v[7:0],
                   exp_v[12:10], exp_v[9], exp_v[8], exp_v[7:0]);
        end
    endtask

    // One clock per queued word; bounded by the queue length.
    task automatic run_q(input string tag);
        while (exp_q.size() != 0) begin
            @(posedge clk);
            #1;
            check_head(tag);
        end
    endtask

    initial begin
        rst         = 1'b0;
        bus.mode    = 2'b00;
        bus.sw_sel  = 3'd0;
        bus.step    = 1'b0;
        bus.ch_mask = 8'hFF;
        bus.evt_req = 8'h00;
        #2;
        push(3'd0, 1'b0, 1'b0, 8'h00, 1);
        check_head("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        push(3'd0, 1'b1, 1'b0, 8'h00, 2);
        run_q("manual_ch0");

        bus.mode = 2'b01;
        for (int k = 0; k < 72; k++) push(3'((k / 8) % 8), 1'b1, 1'b0, 8'h00, 1);
        run_q("auto_full");

        bus.ch_mask = 8'hA4;
        push(3'd2, 1'b1, 1'b0, 8'h00, 8);
        push(3'd5, 1'b1, 1'b0, 8'h00, 8);
        push(3'd7, 1'b1, 1'b0, 8'h00, 8);
        push(3'd2, 1'b1, 1'b0, 8'h00, 1);
        run_q("auto_sparse");

        bus.ch_mask = 8'h00;
        push(3'd2, 1'b0, 1'b0, 8'h00, 10);
        run_q("auto_nomask");

        bus.mode    = 2'b00;
        bus.sw_sel  = 3'd5;
        bus.ch_mask = 8'hDF;
        push(3'd5, 1'b0, 1'b0, 8'h00, 1);
        run_q("manual_masked");
        bus.sw_sel = 3'd3;
        push(3'd3, 1'b1, 1'b0, 8'h00, 1);
        run_q("manual_enabled");

        bus.ch_mask = 8'hFF;
        bus.sw_sel  = 3'd1;
        push(3'd1, 1'b1, 1'b0, 8'h00, 1);
        run_q("manual_ch1");
        bus.mode = 2'b10;
        bus.step = 1'b1;
        push(3'd2, 1'b1, 1'b0, 8'h00, 20);
        run_q("step_held");
        bus.step = 1'b0;
        push(3'd2, 1'b1, 1'b0, 8'h00, 1);
        run_q("step_release");
        bus.step = 1'b1;
        push(3'd3, 1'b1, 1'b0, 8'h00, 1);
        run_q("step_second");
        bus.step = 1'b0;

        bus.mode   = 2'b00;
        bus.sw_sel = 3'd4;
        push(3'd4, 1'b1, 1'b0, 8'h00, 1);
        run_q("manual_ch4");
        bus.mode = 2'b01;
        push(3'd4, 1'b1, 1'b0, 8'h00, 1);
        run_q("auto_ch4");
        bus.evt_req = 8'h41;
        push(3'd4, 1'b1, 1'b0, 8'h00, 1);
        run_q("evt_latch");
        bus.evt_req = 8'h00;
        push(3'd0, 1'b1, 1'b1, 8'h01, 1);
        push(3'd0, 1'b1, 1'b1, 8'h00, 5);
        push(3'd4, 1'b1, 1'b0, 8'h00, 1);
        push(3'd6, 1'b1, 1'b1, 8'h40, 1);
        push(3'd6, 1'b1, 1'b1, 8'h00, 5);
        push(3'd4, 1'b1, 1'b0, 8'h00, 3);
        run_q("evt_b2b");

        bus.mode    = 2'b11;
        bus.evt_req = 8'h04;
        push(3'd4, 1'b1, 1'b0, 8'h00, 1);
        run_q("freeze_req");
        bus.evt_req = 8'h00;
        push(3'd4, 1'b1, 1'b0, 8'h00, 5);
        run_q("freeze_hold");
        bus.mode = 2'b01;
        push(3'd2, 1'b1, 1'b1, 8'h04, 1);
        push(3'd2, 1'b1, 1'b1, 8'h00, 2);
        run_q("unfreeze_grant");

        rst = 1'b0;
        #1;
        push(3'd0, 1'b0, 1'b0, 8'h00, 1);
        check_head("async_reset_mid_evt");
        push(3'd0, 1'b0, 1'b0, 8'h00, 1);
        run_q("reset_held");
        rst = 1'b1;
        push(3'd0, 1'b1, 1'b0, 8'h00, 3);
        run_q("pend_lost");

        bus.ch_mask = 8'hFB;
        bus.evt_req = 8'h04;
        push(3'd0, 1'b1, 1'b0, 8'h00, 1);
        run_q("masked_req");
        bus.evt_req = 8'h00;
        push(3'd0, 1'b1, 1'b0, 8'h00, 2);
        run_q("masked_pending");
        bus.ch_mask = 8'hFF;
        push(3'd2, 1'b1, 1'b1, 8'h04, 1);
        push(3'd2, 1'b1, 1'b1, 8'h00, 5);
        push(3'd0, 1'b1, 1'b0, 8'h00, 1);
        run_q("unmask_grant");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
